wb_mem_arbiter: RTL and testbench
=================================

# wb_mem_arbiter

Two-master Wishbone arbiter and sequencer for a single-port SRAM macro. It lets instruction fetch (master 0) and data/bus traffic (master 1) share one memory port. Memory-port controls are registered, and each access is sequenced as a fixed IDLE/ACCESS/ACK cycle. It sits between the two bus masters and the SRAM macro, in place of a direct single-master memory adapter.

## Interface
- NUM_WMASKS, 4, byte write-mask width
- DATA_WIDTH, 32, SRAM word width
- ADDR_WIDTH, 11, SRAM word-address width
- io_wbs_clk  in  1  single clock for all logic
- io_wbs_rst  in  1  reset; synchronous, active-high
- io_mN_cyc / io_mN_stb / io_mN_we  in  1 each  Wishbone controls of master N (N = 0, 1)
- io_mN_adr  in  32  byte address; bits [ADDR_WIDTH+1:2] used, others ignored
- io_mN_datwr  in  32  write data
- io_mN_sel  in  4  byte selects
- io_mN_datrd  out  32  read data: dout while master N is acked, else 0
- io_mN_ack  out  1  one-cycle acknowledge, registered
- csb  out  1  SRAM chip select, active-low, registered
- web  out  1  SRAM write enable, active-low, registered
- wmask  out  NUM_WMASKS  registered copy of winner's sel
- addr  out  ADDR_WIDTH  registered word address
- din  out  DATA_WIDTH  registered write data
- dout  in  DATA_WIDTH  SRAM read data; valid the cycle after the sampling edge

## Operation
- Request N = io_mN_cyc && io_mN_stb.
- FSM states:
  - IDLE: if any request, pick a winner, load addr/din/wmask from it, set web = ~we, csb = 0 -> ACCESS.
  - ACCESS: controls stable; the SRAM samples at the closing edge; set ack of winner -> ACK.
  - ACK: winner's ack = 1 and its datrd = dout; update the priority pointer to "other master".
    - If the other master requests, load its access directly -> ACCESS (back-to-back).
    - Otherwise csb = 1, web = 1 -> IDLE.
  - The just-acked master cannot be re-granted from ACK; this prevents a false second access on its still-high stb.
- Arbitration: round-robin; the pointer favours the master not served last. On simultaneous requests in IDLE, the pointer's master wins.
- Loser requests stay pending; no ack and no side effects until granted.
- Master drops cyc during ACCESS: the SRAM operation still completes (a write commits) and the ack pulse is still issued; the master ignores it.
- addr/din/wmask hold their last values when idle; only csb/web return inactive.
- Reset (synchronous, any state including mid-ACCESS) sets:
  - state = IDLE, pointer = master 0
  - csb = 1, web = 1
  - addr/din/wmask = 0
  - both acks = 0, both datrd = 0
- A write interrupted by reset before its sampling edge is not performed.

## Timing
- Request seen at edge E0 (IDLE) -> csb low after E0 -> SRAM samples at E1 -> ack high for one cycle after E1, dropped at E2.
- Latency: ack 2 cycles after request; read data valid during the ack cycle.
- Single master: 3 cycles per access (IDLE-ACCESS-ACK).
- Alternating masters: 2 cycles per access via ACK->ACCESS.
- ack is never high for two consecutive cycles on the same master, and is never high on both masters at once.

## Configuration
- WB_MEM_ARB_FIXED_PRIO_EN:
  - Defined: fixed priority. Master 0 always wins IDLE arbitration. The ACK->ACCESS hand-over still serves master 1 only when master 0 is not requesting or was just acked. The pointer register is removed.
  - Undefined (default): round-robin as above.

## Test plan
- Reset, then master 0 writes 0xDEADBEEF to adr 0x10, sel 0xF -> cycle 1: csb=0, web=0, addr=4, din=0xDEADBEEF; cycle 2: io_m0_ack=1; io_m1_ack stays 0.
- Master 1 reads adr 0x10 after that write -> io_m1_ack 2 cycles after request with io_m1_datrd=0xDEADBEEF; io_m0_datrd=0.
- Both request on the same cycle after reset -> master 0 served first, master 1 gets ACCESS directly from ACK, acks 2 cycles apart.
  - With WB_MEM_ARB_FIXED_PRIO_EN and master 0 holding requests, master 1 is served only on the hand-over slot.
- Byte write sel=0x2, datwr=0x0000AB00 over 0xDEADBEEF -> wmask=0x2; a subsequent read returns 0xDEADABEF.
- Assert io_wbs_rst during ACCESS of a write -> next cycle csb=1, web=1, no ack; a later read returns the old data.
- Master 0 issues continuous requests alone -> one ack every 3 cycles, never two consecutive ack cycles.

Source files
------------

// File: rtl/wb_mem_arbiter.sv
// Two-master Wishbone arbiter and sequencer for a single-port SRAM macro; each access runs IDLE/ACCESS/ACK.
// Define WB_MEM_ARB_FIXED_PRIO_EN for fixed master-0 priority; round-robin arbitration otherwise.
module wb_mem_arbiter #(
  parameter int NUM_WMASKS = 4,
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 11
) (
  input  logic                  io_wbs_clk,
  input  logic                  io_wbs_rst,
  input  logic                  io_m0_cyc,
  input  logic                  io_m0_stb,
  input  logic                  io_m0_we,
  input  logic [31:0]           io_m0_adr,
  input  logic [31:0]           io_m0_datwr,
  input  logic [3:0]            io_m0_sel,
  output logic [31:0]           io_m0_datrd,
  output logic                  io_m0_ack,
  input  logic                  io_m1_cyc,
  input  logic                  io_m1_stb,
  input  logic                  io_m1_we,
  input  logic [31:0]           io_m1_adr,
  input  logic [31:0]           io_m1_datwr,
  input  logic [3:0]            io_m1_sel,
  output logic [31:0]           io_m1_datrd,
  output logic                  io_m1_ack,
  output logic                  csb,
  output logic                  web,
  output logic [NUM_WMASKS-1:0] wmask,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic [DATA_WIDTH-1:0] din,
  input  logic [DATA_WIDTH-1:0] dout
);

  typedef enum logic [1:0] {ST_IDLE, ST_ACCESS, ST_ACK} state_t;

  state_t                state_q, state_d;
  logic                  win_q, win_d;
`ifndef WB_MEM_ARB_FIXED_PRIO_EN
  logic                  ptr_q, ptr_d;
`endif
  logic                  csb_q, csb_d;
  logic                  web_q, web_d;
  logic [NUM_WMASKS-1:0] wmask_q, wmask_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] din_q, din_d;
  logic                  ack0_q, ack0_d;
  logic                  ack1_q, ack1_d;
  logic                  req0, req1;
  logic                  grant_v, grant_m;
  logic                  unused_adr;

  assign req0 = io_m0_cyc & io_m0_stb;
  assign req1 = io_m1_cyc & io_m1_stb;

  // Only the word-address field of the byte address reaches the macro.
  assign unused_adr = ^{io_m0_adr[31:ADDR_WIDTH+2], io_m0_adr[1:0],
                        io_m1_adr[31:ADDR_WIDTH+2], io_m1_adr[1:0]};

  always_comb begin
    state_d = state_q;
    win_d   = win_q;
`ifndef WB_MEM_ARB_FIXED_PRIO_EN
    ptr_d   = ptr_q;
`endif
    csb_d   = csb_q;
    web_d   = web_q;
    wmask_d = wmask_q;
    addr_d  = addr_q;
    din_d   = din_q;
    ack0_d  = 1'b0;
    ack1_d  = 1'b0;
    grant_v = 1'b0;
    grant_m = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (req0 | req1) begin
          grant_v = 1'b1;
`ifdef WB_MEM_ARB_FIXED_PRIO_EN
          grant_m = ~req0;
`else
          grant_m = (req0 & req1) ? ptr_q : req1;
`endif
        end
      end
      ST_ACCESS: begin
        state_d = ST_ACK;
        ack0_d  = ~win_q;
        ack1_d  = win_q;
      end
      ST_ACK: begin
`ifndef WB_MEM_ARB_FIXED_PRIO_EN
        ptr_d = ~win_q;
`endif
        // The winner's stb is still high here, so only the other master may be handed the port.
        if (win_q ? req0 : req1) begin
          grant_v = 1'b1;
          grant_m = ~win_q;
        end else begin
          csb_d   = 1'b1;
          web_d   = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (grant_v) begin
      state_d = ST_ACCESS;
      win_d   = grant_m;
      csb_d   = 1'b0;
      if (grant_m) begin
        web_d   = ~io_m1_we;
        addr_d  = io_m1_adr[ADDR_WIDTH+1:2];
        din_d   = DATA_WIDTH'(io_m1_datwr);
        wmask_d = NUM_WMASKS'(io_m1_sel);
      end else begin
        web_d   = ~io_m0_we;
        addr_d  = io_m0_adr[ADDR_WIDTH+1:2];
        din_d   = DATA_WIDTH'(io_m0_datwr);
        wmask_d = NUM_WMASKS'(io_m0_sel);
      end
    end
  end

  always_ff @(posedge io_wbs_clk) begin
    if (io_wbs_rst) begin
      state_q <= ST_IDLE;
      win_q   <= 1'b0;
`ifndef WB_MEM_ARB_FIXED_PRIO_EN
      ptr_q   <= 1'b0;
`endif
      csb_q   <= 1'b1;
      web_q   <= 1'b1;
      wmask_q <= '0;
      addr_q  <= '0;
      din_q   <= '0;
      ack0_q  <= 1'b0;
      ack1_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      win_q   <= win_d;
`ifndef WB_MEM_ARB_FIXED_PRIO_EN
      ptr_q   <= ptr_d;
`endif
      csb_q   <= csb_d;
      web_q   <= web_d;
      wmask_q <= wmask_d;
      addr_q  <= addr_d;
      din_q   <= din_d;
      ack0_q  <= ack0_d;
      ack1_q  <= ack1_d;
    end
  end

  assign csb         = csb_q;
  assign web         = web_q;
  assign wmask       = wmask_q;
  assign addr        = addr_q;
  assign din         = din_q;
  assign io_m0_ack   = ack0_q;
  assign io_m1_ack   = ack1_q;
  assign io_m0_datrd = ack0_q ? 32'(dout) : 32'd0;
  assign io_m1_datrd = ack1_q ? 32'(dout) : 32'd0;

endmodule

// File: tb/tb_wb_mem_arbiter.sv
// Bench for wb_mem_arbiter: directed bring-up sequences, then random two-master traffic
// checked against a slot-timing and memory-contents reference model.
module tb_wb_mem_arbiter;

  localparam int AW = 11;

  logic          clk = 1'b0;
  logic          rst;
  logic          m0_cyc, m0_stb, m0_we, m0_ack;
  logic [31:0]   m0_adr, m0_datwr, m0_datrd;
  logic [3:0]    m0_sel;
  logic          m1_cyc, m1_stb, m1_we, m1_ack;
  logic [31:0]   m1_adr, m1_datwr, m1_datrd;
  logic [3:0]    m1_sel;
  logic          csb, web;
  logic [3:0]    wmask;
  logic [AW-1:0] addr;
  logic [31:0]   din, dout;
  logic          sram_clr;
  logic [31:0]   sram [0:(1<<AW)-1];

  int n_chk, n_pass;

  always #5 clk = ~clk;

  wb_mem_arbiter #(.NUM_WMASKS(4), .DATA_WIDTH(32), .ADDR_WIDTH(AW)) dut (
    .io_wbs_clk(clk), .io_wbs_rst(rst),
    .io_m0_cyc(m0_cyc), .io_m0_stb(m0_stb), .io_m0_we(m0_we), .io_m0_adr(m0_adr),
    .io_m0_datwr(m0_datwr), .io_m0_sel(m0_sel), .io_m0_datrd(m0_datrd), .io_m0_ack(m0_ack),
    .io_m1_cyc(m1_cyc), .io_m1_stb(m1_stb), .io_m1_we(m1_we), .io_m1_adr(m1_adr),
    .io_m1_datwr(m1_datwr), .io_m1_sel(m1_sel), .io_m1_datrd(m1_datrd), .io_m1_ack(m1_ack),
    .csb(csb), .web(web), .wmask(wmask), .addr(addr), .din(din), .dout(dout)
  );

  // SRAM macro: samples at the rising edge, read data valid the following cycle.
  // The macro is held deselected while the system is in reset.
  always @(posedge clk) begin
    if (sram_clr) begin
      for (int i = 0; i < (1 << AW); i++) sram[i] <= '0;
    end else if (!(csb | rst)) begin
      if (!web) begin
        for (int b = 0; b < 4; b++)
          if (wmask[b]) sram[addr][8*b +: 8] <= din[8*b +: 8];
      end else begin
        dout <= sram[addr];
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_chk++;
    if (obs === expv) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, expv);
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic drive(input int m, input logic req, input logic we, input logic [31:0] adr,
                       input logic [31:0] dat, input logic [3:0] sel);
    if (m == 0) begin
      m0_cyc = req; m0_stb = req; m0_we = we; m0_adr = adr; m0_datwr = dat; m0_sel = sel;
    end else begin
      m1_cyc = req; m1_stb = req; m1_we = we; m1_adr = adr; m1_datwr = dat; m1_sel = sel;
    end
  endtask

  // Reference model state: slot timing plus expected memory contents.
  int          e, fav, idle_free, ho_edge, ho_m;
  int          ack_edge [2];
  logic        act [2];
  logic        acked_prev [2];
  int          gap [2];
  logic        t_we [2];
  int          t_idx [2];
  logic [31:0] t_adr [2];
  logic [31:0] t_dat [2];
  logic [3:0]  t_sel [2];
  logic [31:0] ref_mem [16];

  // A grant at edge t acks during the cycle after t+1; the other master may take the port
  // at t+2, and a fresh arbitration from idle is possible from t+3.
  task automatic grant(input int w, input int t);
    ack_edge[w] = t + 1;
    ho_edge     = t + 2;
    ho_m        = 1 - w;
    idle_free   = t + 3;
`ifdef WB_MEM_ARB_FIXED_PRIO_EN
    fav = 0;
`else
    fav = 1 - w;
`endif
  endtask

  task automatic new_txn(input int m);
    act[m]   = 1'b1;
    t_we[m]  = 1'($urandom_range(1));
    t_idx[m] = int'($urandom_range(15));
    t_adr[m] = ($urandom & 32'hFFFF_E003) | (32'(t_idx[m]) << 2);
    t_dat[m] = $urandom;
    t_sel[m] = 4'($urandom_range(15));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not reach its end");
    $fatal(1);
  end

  initial begin
    n_chk = 0; n_pass = 0;
    rst = 1'b1; sram_clr = 1'b1;
    drive(0, 0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 0);
    step(); step();
    sram_clr = 1'b0;
    check("rst_csb", 32'(csb), 1);
    check("rst_web", 32'(web), 1);
    check("rst_addr", 32'(addr), 0);
    check("rst_din", din, 0);
    check("rst_wmask", 32'(wmask), 0);
    check("rst_ack0", 32'(m0_ack), 0);
    check("rst_ack1", 32'(m1_ack), 0);
    check("rst_datrd0", m0_datrd, 0);
    check("rst_datrd1", m1_datrd, 0);
    rst = 1'b0;
    step();

    // Master 0 full-word write.
    drive(0, 1, 1, 32'h10, 32'hDEADBEEF, 4'hF);
    step();
    check("wr_csb", 32'(csb), 0);
    check("wr_web", 32'(web), 0);
    check("wr_addr", 32'(addr), 4);
    check("wr_din", din, 32'hDEADBEEF);
    check("wr_wmask", 32'(wmask), 4'hF);
    check("wr_ack0_early", 32'(m0_ack), 0);
    step();
    check("wr_ack0", 32'(m0_ack), 1);
    check("wr_ack1", 32'(m1_ack), 0);
    drive(0, 0, 0, 0, 0, 0);
    step();
    check("wr_ack0_drop", 32'(m0_ack), 0);
    check("idle_csb", 32'(csb), 1);
    check("idle_web", 32'(web), 1);
    check("idle_addr_hold", 32'(addr), 4);
    check("idle_din_hold", din, 32'hDEADBEEF);

    // Master 1 reads it back.
    drive(1, 1, 0, 32'h10, 0, 4'hF);
    step();
    check("rd_web", 32'(web), 1);
    check("rd_ack1_early", 32'(m1_ack), 0);
    step();
    check("rd_ack1", 32'(m1_ack), 1);
    check("rd_datrd1", m1_datrd, 32'hDEADBEEF);
    check("rd_datrd0", m0_datrd, 0);
    check("rd_ack0", 32'(m0_ack), 0);
    drive(1, 0, 0, 0, 0, 0);
    step();
    check("rd_datrd1_idle", m1_datrd, 0);

    // Byte write then read back.
    drive(0, 1, 1, 32'h10, 32'h0000AB00, 4'h2);
    step();
    check("bw_wmask", 32'(wmask), 4'h2);
    step();
    check("bw_ack0", 32'(m0_ack), 1);
    drive(0, 0, 0, 0, 0, 0);
    step();
    drive(0, 1, 0, 32'h10, 0, 4'hF);
    step(); step();
    check("bw_rd_ack0", 32'(m0_ack), 1);
    check("bw_rd_data", m0_datrd, 32'hDEADABEF);
    drive(0, 0, 0, 0, 0, 0);
    step();

    // Simultaneous requests straight after reset.
    rst = 1'b1;
    step();
    rst = 1'b0;
    drive(0, 1, 0, 32'h0, 0, 4'hF);
    drive(1, 1, 0, 32'h10, 0, 4'hF);
    step();
    check("sim_addr_m0", 32'(addr), 0);
    step();
    check("sim_ack0", 32'(m0_ack), 1);
    check("sim_ack1_wait", 32'(m1_ack), 0);
    drive(0, 0, 0, 0, 0, 0);
    step();
    check("sim_handover_csb", 32'(csb), 0);
    check("sim_handover_addr", 32'(addr), 4);
    check("sim_gap_ack0", 32'(m0_ack), 0);
    check("sim_gap_ack1", 32'(m1_ack), 0);
    step();
    check("sim_ack1", 32'(m1_ack), 1);
    check("sim_datrd1", m1_datrd, 32'hDEADABEF);
    check("sim_ack0_off", 32'(m0_ack), 0);
    drive(1, 0, 0, 0, 0, 0);
    step();

    // Reset during the ACCESS cycle of a write: write dropped, no ack.
    drive(0, 1, 1, 32'h10, 32'h12345678, 4'hF);
    step();
    check("rw_csb_access", 32'(csb), 0);
    rst = 1'b1;
    step();
    check("rw_csb", 32'(csb), 1);
    check("rw_web", 32'(web), 1);
    check("rw_ack0", 32'(m0_ack), 0);
    check("rw_addr", 32'(addr), 0);
    rst = 1'b0;
    drive(0, 0, 0, 0, 0, 0);
    step();
    check("rw_ack0_after", 32'(m0_ack), 0);
    drive(1, 1, 0, 32'h10, 0, 4'hF);
    step(); step();
    check("rw_rd_ack1", 32'(m1_ack), 1);
    check("rw_old_data", m1_datrd, 32'hDEADABEF);
    drive(1, 0, 0, 0, 0, 0);
    step();

    // Master 0 alone with stb held high: one ack every third cycle.
    drive(0, 1, 0, 32'h10, 0, 4'hF);
    for (int k = 0; k < 12; k++) begin
      step();
      check("cont_ack0", 32'(m0_ack), 32'((k % 3) == 1));
      check("cont_ack1", 32'(m1_ack), 0);
    end
    drive(0, 0, 0, 0, 0, 0);
    step(); step();

    // Random two-master traffic against the reference model.
    rst = 1'b1; sram_clr = 1'b1;
    step(); step();
    sram_clr = 1'b0; rst = 1'b0;
    e = 0; fav = 0; idle_free = 0; ho_edge = -10; ho_m = 0;
    for (int i = 0; i < 16; i++) ref_mem[i] = '0;
    for (int m = 0; m < 2; m++) begin
      ack_edge[m] = -10; act[m] = 1'b0; acked_prev[m] = 1'b0; gap[m] = 0;
      t_we[m] = 1'b0; t_idx[m] = 0; t_adr[m] = '0; t_dat[m] = '0; t_sel[m] = '0;
    end
    for (int cyc = 0; cyc < 1500; cyc++) begin
      for (int m = 0; m < 2; m++) begin
        logic        a;
        logic [31:0] d;
        a = (m == 0) ? m0_ack : m1_ack;
        d = (m == 0) ? m0_datrd : m1_datrd;
        if (m == 0) check("rnd_ack0", 32'(a), 32'(ack_edge[m] == e));
        else        check("rnd_ack1", 32'(a), 32'(ack_edge[m] == e));
        if (ack_edge[m] == e) begin
          if (!t_we[m]) check("rnd_rdata", d, ref_mem[t_idx[m]]);
          else
            for (int b = 0; b < 4; b++)
              if (t_sel[m][b]) ref_mem[t_idx[m]][8*b +: 8] = t_dat[m][8*b +: 8];
        end else begin
          check("rnd_datrd_idle", d, 0);
        end
      end
      for (int m = 0; m < 2; m++) begin
        if (acked_prev[m]) begin
          if ($urandom_range(2) == 0) new_txn(m);
          else begin
            act[m] = 1'b0;
            gap[m] = int'($urandom_range(3));
          end
        end else if (!act[m]) begin
          if (gap[m] > 0) gap[m]--;
          else if ($urandom_range(1) == 1) new_txn(m);
        end
        acked_prev[m] = (ack_edge[m] == e);
        drive(m, act[m], t_we[m], t_adr[m], t_dat[m], t_sel[m]);
      end
      if ((e + 1) == ho_edge && act[ho_m]) grant(ho_m, e + 1);
      else if ((e + 1) >= idle_free && (act[0] || act[1]))
        grant((act[0] && act[1]) ? fav : (act[0] ? 0 : 1), e + 1);
      step();
      e++;
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
